// File: rtl/pio_devctrl_pkg.sv
// rtl/pio_devctrl_pkg.sv - shared FSM encoding and timing defaults for pio_devctrl
package pio_devctrl_pkg;

  localparam int TWIDTH_DEF = 8;
  localparam int TDH_DEF    = 2;
  localparam int TMO_DEF    = 120;
  localparam int TRD_DEF    = 1;

  localparam logic [15:0] TMO_RDATA = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_RD_HOLD = 3'd3,
    ST_WR_ACT  = 3'd4,
    ST_WR_WAIT = 3'd5
  } state_t;

endpackage

// File: rtl/pio_devctrl_if.sv
// rtl/pio_devctrl_if.sv - ATA PIO bus between a host and the pio_devctrl device side
interface pio_devctrl_if;

  logic        DIOR;
  logic        DIOW;
  logic        CS0;
  logic        CS1;
  logic [2:0]  DA;
  logic [15:0] DDi;
  logic [15:0] DDo;
  logic        DDoe;
  logic        IORDY;

  modport master (output DIOR, DIOW, CS0, CS1, DA, DDi, input DDo, DDoe, IORDY);
  modport slave  (input DIOR, DIOW, CS0, CS1, DA, DDi, output DDo, DDoe, IORDY);

endinterface

// File: rtl/pio_dev_cnt.sv
// rtl/pio_dev_cnt.sv - loadable saturating down-counter; done while the count is zero
module pio_dev_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pio_devctrl.sv
// rtl/pio_devctrl.sv - ATA PIO device controller bridging host strobes to a register backend
module pio_devctrl
  import pio_devctrl_pkg::*;
#(
  parameter int TWIDTH = TWIDTH_DEF,
  parameter int TDH    = TDH_DEF,
  parameter int TMO    = TMO_DEF,
  parameter int TRD    = TRD_DEF
) (
  input  logic         clk,
  input  logic         rst,
  pio_devctrl_if.slave ata,
  output logic [3:0]   reg_adr,
  output logic         reg_re,
  output logic         reg_we,
  output logic [15:0]  reg_wdat,
  input  logic [15:0]  reg_rdat,
  input  logic         reg_ack,
  output logic         err
);

  logic [1:0]  dior_q, diow_q, cs0_q, cs1_q, fill;
  logic [2:0]  da_q1, da_s;
  logic [15:0] ddi_q1, ddi_s;
  logic        dior_s, diow_s, cs0_s, cs1_s, addr_ok, armed;

  state_t state, state_nxt;
  logic   start_rd, start_wr, strobe_err, arm_clr, rd_ack, rd_tmo, wr_fire, hold_end;
  logic   tmo_done, trd_done, hold_done, tmo_load, trd_load, hold_load;

  logic [15:0] ddo;
  logic        ddoe, iordy;

  always_ff @(posedge clk) begin
    if (rst) begin
      dior_q <= '0;
      diow_q <= '0;
      cs0_q  <= '0;
      cs1_q  <= '0;
      da_q1  <= '0;
      da_s   <= '0;
      ddi_q1 <= '0;
      ddi_s  <= '0;
      fill   <= '0;
    end else begin
      dior_q <= {dior_q[0], ata.DIOR};
      diow_q <= {diow_q[0], ata.DIOW};
      cs0_q  <= {cs0_q[0], ata.CS0};
      cs1_q  <= {cs1_q[0], ata.CS1};
      da_q1  <= ata.DA;
      da_s   <= da_q1;
      ddi_q1 <= ata.DDi;
      ddi_s  <= ddi_q1;
      fill   <= {fill[0], 1'b1};
    end
  end

  assign dior_s  = dior_q[1];
  assign diow_s  = diow_q[1];
  assign cs0_s   = cs0_q[1];
  assign cs1_s   = cs1_q[1];
  assign addr_ok = cs0_s ^ cs1_s;

  // fill gates arming so reset-cleared synchronizer zeros never count as a negated strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (arm_clr) begin
      armed <= 1'b0;
    end else if (fill[1] && !dior_s && !diow_s) begin
      armed <= 1'b1;
    end
  end

  assign tmo_load  = (state != ST_RD_WAIT);
  assign trd_load  = (state != ST_RD_DATA);
  assign hold_load = !((state == ST_RD_HOLD) || (state == ST_RD_DATA && !dior_s));

  pio_dev_cnt #(.WIDTH(TWIDTH)) u_tmo (
    .clk(clk), .rst(rst), .load(tmo_load), .load_val(TWIDTH'(TMO - 1)), .done(tmo_done)
  );

  pio_dev_cnt #(.WIDTH(TWIDTH)) u_trd (
    .clk(clk), .rst(rst), .load(trd_load), .load_val(TWIDTH'(TRD)), .done(trd_done)
  );

  // hold time counts from the cycle DIOR_s is first seen low, even before RD_HOLD is entered
  pio_dev_cnt #(.WIDTH(TWIDTH)) u_hold (
    .clk(clk), .rst(rst), .load(hold_load), .load_val(TWIDTH'(TDH - 1)), .done(hold_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    start_rd   = 1'b0;
    start_wr   = 1'b0;
    strobe_err = 1'b0;
    arm_clr    = 1'b0;
    rd_ack     = 1'b0;
    rd_tmo     = 1'b0;
    wr_fire    = 1'b0;
    hold_end   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (armed && (dior_s || diow_s)) begin
          arm_clr = 1'b1;
          if (dior_s && diow_s) begin
            strobe_err = 1'b1;
          end else if (addr_ok) begin
            if (dior_s) begin
              start_rd  = 1'b1;
              state_nxt = ST_RD_WAIT;
            end else begin
              start_wr  = 1'b1;
              state_nxt = ST_WR_ACT;
            end
          end
        end
      end
      ST_RD_WAIT: begin
        if (reg_ack) begin
          rd_ack    = 1'b1;
          state_nxt = ST_RD_DATA;
        end else if (tmo_done) begin
          rd_tmo    = 1'b1;
          state_nxt = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (!dior_s) state_nxt = ST_RD_HOLD;
      end
      ST_RD_HOLD: begin
        if (hold_done) begin
          hold_end  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WR_ACT: begin
        if (!diow_s) begin
          wr_fire   = 1'b1;
          state_nxt = ST_WR_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (reg_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    iordy = 1'b1;
    case (state)
      ST_RD_WAIT: iordy = 1'b0;
      ST_RD_DATA: iordy = trd_done;
      ST_WR_WAIT: iordy = !(dior_s || diow_s);
      default:    iordy = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ddo      <= '0;
      ddoe     <= 1'b0;
      reg_adr  <= '0;
      reg_re   <= 1'b0;
      reg_we   <= 1'b0;
      reg_wdat <= '0;
      err      <= 1'b0;
    end else begin
      reg_re <= start_rd;
      reg_we <= wr_fire;
      err    <= strobe_err | rd_tmo;
      if (start_rd || start_wr) reg_adr <= {cs1_s, da_s};
      if (wr_fire) reg_wdat <= ddi_s;
      if (rd_ack) begin
        ddo  <= reg_rdat;
        ddoe <= 1'b1;
      end else if (rd_tmo) begin
        ddo  <= TMO_RDATA;
        ddoe <= 1'b1;
      end else if (hold_end) begin
        ddoe <= 1'b0;
      end
    end
  end

  assign ata.DDo   = ddo;
  assign ata.DDoe  = ddoe;
  assign ata.IORDY = iordy;

endmodule
